ppu_pixel_fifo: RTL

Parametrised pixel FIFO for the PPU draw path, superseding the fixed 8-pixel shift register used by the fetchers. It accepts whole 8-pixel tile rows as two bitplanes, holds up to DEPTH pixels with per-pixel attribute bits, and supports sprite overlay merge into the oldest 8 entries. It also supports fine-scroll discard of leading pixels and a ready/valid pop port toward the pixel mixer. The PPU top instantiates one copy for background/window (push mode) and one for sprites (merge mode).

---
 rtl/ppu_pixel_fifo_if.sv | 41 ++++
 rtl/ppu_pixel_fifo.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ppu_pixel_fifo_if.sv
// ppu_pixel_fifo_if: handshake and data bundle for the PPU pixel FIFO.
//   master - fetcher/mixer side: drives flush, push row, merge, drop and
//            pop_ready; observes push_ready, drop_busy, pop_* and count.
//   slave  - FIFO side (mirror of master).
// Parameters must match those of the ppu_pixel_fifo instance it connects to.
interface ppu_pixel_fifo_if #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PX_W   = 2,
  parameter int unsigned ATTR_W = 2
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              push_valid;
  logic              push_ready;
  logic [7:0]        row_lo;
  logic [7:0]        row_hi;
  logic [ATTR_W-1:0] row_attr;
  logic              row_flip;
  logic              merge_valid;
  logic              drop_valid;
  logic [2:0]        drop_n;
  logic              drop_busy;
  logic              pop_valid;
  logic              pop_ready;
  logic [PX_W-1:0]   pop_px;
  logic [ATTR_W-1:0] pop_attr;
  logic [CW-1:0]     count;

  modport master (
    output flush, push_valid, row_lo, row_hi, row_attr, row_flip,
           merge_valid, drop_valid, drop_n, pop_ready,
    input  push_ready, drop_busy, pop_valid, pop_px, pop_attr, count
  );

  modport slave (
    input  flush, push_valid, row_lo, row_hi, row_attr, row_flip,
           merge_valid, drop_valid, drop_n, pop_ready,
    output push_ready, drop_busy, pop_valid, pop_px, pop_attr, count
  );
endinterface

// File: rtl/ppu_pixel_fifo.sv
// ppu_pixel_fifo: circular pixel FIFO for the PPU draw path.
// Accepts 8-pixel tile rows as two bitplanes, overlays sprite rows onto the
// oldest 8 entries (earlier non-zero colour wins), discards 0-7 leading
// pixels for fine scroll, and presents the head pixel on a ready/valid port.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset
//   bus  - ppu_pixel_fifo_if.slave (flush, push, merge, drop, pop, count)
// Optional build macro: PPU_FIFO_FLIP_EN - honour row_flip on push and merge;
// when undefined row_flip is ignored and no flip mux exists.
module ppu_pixel_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PX_W   = 2,
  parameter int unsigned ATTR_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  ppu_pixel_fifo_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    S_IDLE,
    S_DROP
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PX_W-1:0]   px_q   [DEPTH];
  logic [PX_W-1:0]   px_d   [DEPTH];
  logic [ATTR_W-1:0] attr_q [DEPTH];
  logic [ATTR_W-1:0] attr_d [DEPTH];

  logic [PX_W-1:0]   row_px [8];
  logic              push_ready;
  logic              pop_valid;
  logic              drop_busy;

`ifndef PPU_FIFO_FLIP_EN
  // row_flip is deliberately unread in the non-flip build.
  logic unused_row_flip;
  assign unused_row_flip = bus.row_flip;
`endif

  // Row pixel k (k=0 leftmost). Truncating {hi,lo} keeps only the lo plane
  // when PX_W=1.
  always_comb begin
    logic [2:0] idx;
    for (int unsigned k = 0; k < 8; k++) begin
`ifdef PPU_FIFO_FLIP_EN
      idx = bus.row_flip ? 3'(k) : 3'(7 - k);
`else
      idx = 3'(7 - k);
`endif
      row_px[k] = PX_W'({bus.row_hi[idx], bus.row_lo[idx]});
    end
  end

  assign drop_busy  = (drop_cnt_q != '0);
  assign push_ready = (count_q <= CW'(DEPTH - 8)) && !bus.merge_valid && !bus.flush;
  assign pop_valid  = (count_q != '0) && !drop_busy && !bus.merge_valid && !bus.flush;

  assign bus.push_ready = push_ready;
  assign bus.pop_valid  = pop_valid;
  assign bus.drop_busy  = drop_busy;
  assign bus.count      = count_q;
  assign bus.pop_px     = (count_q != '0) ? px_q[rd_ptr_q]   : '0;
  assign bus.pop_attr   = (count_q != '0) ? attr_q[rd_ptr_q] : '0;

  always_comb begin
    logic [PW-1:0] slot;
    logic          remove;
    logic          push_fire;

    state_d    = state_q;
    drop_cnt_d = drop_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    px_d       = px_q;
    attr_d     = attr_q;
    slot       = '0;
    remove     = 1'b0;
    push_fire  = bus.push_valid && push_ready;

    if (bus.flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      drop_cnt_d = '0;
    end else begin
      if (bus.merge_valid) begin
        // Slots beyond current occupancy take the new pixel outright; live
        // slots only accept it over a transparent existing pixel.
        for (int unsigned i = 0; i < 8; i++) begin
          slot = rd_ptr_q + PW'(i);
          if ((CW'(i) >= count_q) || ((px_q[slot] == '0) && (row_px[i] != '0))) begin
            px_d[slot]   = row_px[i];
            attr_d[slot] = bus.row_attr;
          end
        end
        count_d  = (count_q < CW'(8)) ? CW'(8) : count_q;
        wr_ptr_d = rd_ptr_q + count_d[PW-1:0];
      end else begin
        if (drop_busy && (count_q != '0)) begin
          remove     = 1'b1;
          drop_cnt_d = drop_cnt_q - 3'd1;
        end else if (pop_valid && bus.pop_ready) begin
          remove = 1'b1;
        end

        if (push_fire) begin
          for (int unsigned k = 0; k < 8; k++) begin
            slot         = wr_ptr_q + PW'(k);
            px_d[slot]   = row_px[k];
            attr_d[slot] = bus.row_attr;
          end
          wr_ptr_d = wr_ptr_q + PW'(8);
        end

        if (remove) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + (push_fire ? CW'(8) : '0) - (remove ? CW'(1) : '0);
      end

      // A new non-zero request reloads the counter, also mid-discard.
      if (bus.drop_valid && (bus.drop_n != '0)) drop_cnt_d = bus.drop_n;
    end

    state_d = (drop_cnt_d != '0) ? S_DROP : S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      drop_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      px_q       <= '{default: '0};
      attr_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      px_q       <= px_d;
      attr_q     <= attr_d;
    end
  end
endmodule
